// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the fetch PC, issues one instruction request at a time,
// and hands each fetched word to decode, honouring branch redirects and downstream stalls.
module stage_if #(
   parameter logic [31:0] PC_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] PC,
   output logic        Inst_Req_Valid,
   input  logic        Inst_Req_Ready,
   input  logic [31:0] Instruction,
   input  logic        Inst_Valid,
   output logic        Inst_Ready,
   input  logic        Feedback_Mem_Acc,
   input  logic        Feedback_Branch,
   input  logic [31:0] Branch_Target,
   output logic [31:0] Inst,
   output logic [31:0] PC_O,
   output logic        Done_O,
   output logic [3:0]  State_O
);

   // Request: a transfer occurs on a clock edge where Inst_Req_Valid and Inst_Req_Ready are both 1.
   // Response: a transfer occurs on a clock edge where Inst_Valid and Inst_Ready are both 1.
   typedef enum logic [3:0] {
      s_INIT = 4'b0001,
      s_IF   = 4'b0010,
      s_IW   = 4'b0100,
      s_OUT  = 4'b1000
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_o_q, pc_o_d;
   logic        done_q, done_d;

   logic        redirect;
   logic [31:0] target;

   // A redirect raised while decode is frozen is not seen until the stall lifts.
   assign redirect = Feedback_Branch & ~Feedback_Mem_Acc;
   assign target   = Branch_Target & 32'hFFFF_FFFC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= s_INIT;
         pc_q     <= PC_RESET & 32'hFFFF_FFFC;
         squash_q <= 1'b0;
         inst_q   <= 32'h0;
         pc_o_q   <= 32'h0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         squash_q <= squash_d;
         inst_q   <= inst_d;
         pc_o_q   <= pc_o_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      inst_d   = inst_q;
      pc_o_d   = pc_o_q;
      done_d   = done_q;
      case (state_q)
         s_INIT: state_d = s_IF;
         s_IF: begin
            if (Inst_Req_Ready) begin
               state_d = s_IW;
               // The old PC already went out, so its response must be thrown away.
               if (redirect) begin
                  squash_d = 1'b1;
                  pc_d     = target;
               end
            end else if (redirect) begin
               pc_d = target;
            end
         end
         s_IW: begin
            if (Inst_Valid) begin
               if (squash_q || redirect) begin
                  squash_d = 1'b0;
                  state_d  = s_IF;
                  if (redirect) pc_d = target;
               end else begin
                  inst_d  = Instruction;
                  pc_o_d  = pc_q;
                  done_d  = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = s_OUT;
               end
            end else if (redirect) begin
               squash_d = 1'b1;
               pc_d     = target;
            end
         end
         s_OUT: begin
            if (!Feedback_Mem_Acc) begin
               done_d  = 1'b0;
               state_d = s_IF;
               if (redirect) pc_d = target;
            end
         end
         default: state_d = s_INIT;
      endcase
   end

   assign PC             = pc_q;
   assign Inst_Req_Valid = (state_q == s_IF);
   assign Inst_Ready     = (state_q == s_IW);
   assign Inst           = inst_q;
   assign PC_O           = pc_o_q;
   assign Done_O         = done_q;
   assign State_O        = state_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: a scripted memory plus a transaction-level fetch model predicts
// every request address and every delivered instruction, for directed and random traffic.
module tb_stage_if;

  localparam logic [31:0] PC_RST = 32'h1C00_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc, instr, bt, inst, pc_o;
  logic        irv, irr, iv, ir, fma, fb, done;
  logic [3:0]  dbg_state;

  stage_if #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC(pc), .Inst_Req_Valid(irv), .Inst_Req_Ready(irr),
    .Instruction(instr), .Inst_Valid(iv), .Inst_Ready(ir),
    .Feedback_Mem_Acc(fma), .Feedback_Branch(fb), .Branch_Target(bt),
    .Inst(inst), .PC_O(pc_o), .Done_O(done), .State_O(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;

  // memory behaviour knobs and state
  int req_dly = 0, rsp_dly = 0, wait_cnt = 0, rsp_cnt = 0;
  bit busy = 0, stale = 0;
  logic [31:0] mem_addr = 32'h0;

  // feedback drive knobs
  bit drv_stall = 0, drv_br = 0;
  logic [31:0] drv_tgt = 32'h0;

  // reference model: next fetch address, address of the outstanding request, squash of it
  logic [31:0] m_pc = PC_RST;
  logic [31:0] pend_addr = 32'h0;
  bit pend_sq = 0, exp_new = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    int          req_dly;
    int          rsp_dly;
    int          stall_n;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 ^ (a - PC_RST);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: called at a falling edge, drives inputs, predicts the next rising edge, checks after it.
  task automatic tick();
    logic acc, rsp, red, done_b, stall_b, irv_b;
    logic [31:0] inst_b, pco_b, pc_b;
    logic [63:0] e;
    if (stale) begin
      iv = 1'b1; instr = 32'hDEAD_BEEF;
    end else if (busy && rsp_cnt >= rsp_dly) begin
      iv = 1'b1; instr = mem_word(mem_addr);
    end else begin
      iv = 1'b0; instr = $urandom;
    end
    irr = (!busy && wait_cnt >= req_dly);
    fma = drv_stall; fb = drv_br; bt = drv_tgt;

    acc = irv & irr;
    rsp = iv & ir & !stale;
    red = fb & !fma;
    if (stale) check32("stale_ignored", {31'b0, ir}, 32'd0);
    if (acc) begin
      check32("req_pc", pc, m_pc);
      pend_addr = m_pc;
      pend_sq = 1'b0;
    end
    if (rsp) begin
      if (!pend_sq && !red) begin
        exp_q.push_back({pend_addr, mem_word(pend_addr)});
        exp_new = 1'b1;
        m_pc = pend_addr + 32'd4;
      end
      pend_sq = 1'b0;
    end
    if (red) begin
      m_pc = drv_tgt & 32'hFFFF_FFFC;
      if (acc || (busy && !rsp)) pend_sq = 1'b1;
    end

    if (rsp) busy = 1'b0;
    else if (busy) rsp_cnt++;
    if (acc) begin
      busy = 1'b1; mem_addr = pc; rsp_cnt = 0; wait_cnt = 0; stale = 1'b0;
    end else if (irv && !busy && !irr) begin
      wait_cnt++;
    end

    done_b = done; stall_b = fma; inst_b = inst; pco_b = pc_o; irv_b = irv; pc_b = pc;
    @(posedge clk);
    @(negedge clk);

    if (exp_new) begin
      exp_new = 1'b0;
      e = exp_q.pop_front();
      n_deliv++;
      check32("deliver_done", {31'b0, done}, 32'd1);
      check32("deliver_pc", pc_o, e[63:32]);
      check32("deliver_inst", inst, e[31:0]);
    end else if (done_b && stall_b) begin
      check32("stall_done", {31'b0, done}, 32'd1);
      check32("stall_inst", inst, inst_b);
      check32("stall_pc_o", pc_o, pco_b);
    end else begin
      check32("no_done", {31'b0, done}, 32'd0);
    end
    if (irv_b && !acc && !red && irv) check32("pc_stable", pc, pc_b);
  endtask

  task automatic run_until_done(input int max_cycles);
    int start;
    start = n_deliv;
    for (int i = 0; i < max_cycles && n_deliv == start; i++) tick();
    if (n_deliv == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no Done_O within %0d cycles", max_cycles);
    end
  endtask

  task automatic release_check(input logic [31:0] exp_pc);
    drv_stall = 0;
    tick();
    check32("next_req_valid", {31'b0, irv}, 32'd1);
    check32("next_req_pc", pc, exp_pc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 0, PC_RST + 32'h4};
    vecs[1] = '{3, 4, 0, PC_RST + 32'h8};
    vecs[2] = '{0, 0, 5, PC_RST + 32'hC};
    vecs[3] = '{1, 2, 2, PC_RST + 32'h10};
    vecs[4] = '{2, 0, 1, PC_RST + 32'h14};

    irr = 0; iv = 0; instr = 0; fma = 0; fb = 0; bt = 0;

    // reset state
    @(negedge clk);
    check32("rst_req_valid", {31'b0, irv}, 32'd0);
    check32("rst_inst_ready", {31'b0, ir}, 32'd0);
    check32("rst_done", {31'b0, done}, 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_pc_o", pc_o, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check32("init_req_valid", {31'b0, irv}, 32'd0);

    // first fetch, best-case memory
    run_until_done(10);
    check32("first_pc_o", pc_o, PC_RST);
    check32("first_inst", inst, 32'h0000_0013);
    release_check(PC_RST + 32'h4);

    // table: memory latency and stall length per fetch
    foreach (vecs[k]) begin
      req_dly = vecs[k].req_dly;
      rsp_dly = vecs[k].rsp_dly;
      run_until_done(40);
      check32("tbl_pc_o", pc_o, vecs[k].exp_pc);
      check32("tbl_inst", inst, mem_word(vecs[k].exp_pc));
      drv_stall = 1;
      repeat (vecs[k].stall_n) tick();
      release_check(vecs[k].exp_pc + 32'h4);
    end

    // redirect while a response is pending
    req_dly = 0; rsp_dly = 3;
    tick();
    drv_br = 1; drv_tgt = 32'h0000_0103;
    tick();
    drv_br = 0;
    run_until_done(30);
    check32("redir_iw_pc_o", pc_o, 32'h0000_0100);

    // redirect on the same edge as the request handshake
    release_check(32'h0000_0104);
    rsp_dly = 1;
    drv_br = 1; drv_tgt = 32'h0000_0200;
    tick();
    drv_br = 0;
    run_until_done(30);
    check32("redir_if_pc_o", pc_o, 32'h0000_0200);

    // redirect during stall is ignored until the stall lifts
    drv_stall = 1; drv_br = 1; drv_tgt = 32'h0000_0300;
    repeat (3) tick();
    release_check(32'h0000_0300);
    drv_br = 0;
    run_until_done(30);
    check32("redir_stall_pc_o", pc_o, 32'h0000_0300);

    // wrap at the top of the address space
    release_check(32'h0000_0304);
    req_dly = 2;
    drv_br = 1; drv_tgt = 32'hFFFF_FFFF;
    tick();
    drv_br = 0;
    run_until_done(30);
    check32("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
    req_dly = 0;
    release_check(32'h0000_0000);

    // asynchronous reset while waiting for a response
    rsp_dly = 4;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check32("arst_req_valid", {31'b0, irv}, 32'd0);
    check32("arst_inst_ready", {31'b0, ir}, 32'd0);
    check32("arst_done", {31'b0, done}, 32'd0);
    check32("arst_inst", inst, 32'd0);
    check32("arst_pc_o", pc_o, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    busy = 0; stale = 1; wait_cnt = 0; rsp_cnt = 0;
    m_pc = PC_RST; pend_sq = 0; exp_new = 0; exp_q.delete();
    @(negedge clk);
    check32("arst_init_req_valid", {31'b0, irv}, 32'd0);
    rsp_dly = 1;
    run_until_done(20);
    check32("arst_pc_o_after", pc_o, PC_RST);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      req_dly   = $urandom_range(0, 3);
      rsp_dly   = $urandom_range(0, 3);
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_br    = ($urandom_range(0, 11) == 0);
      drv_tgt   = $urandom;
      tick();
    end
    drv_stall = 0; drv_br = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the turbo RV32 pipeline, directly upstream of the decode stage. It owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request and response handshake. It presents each fetched word, with its PC and a `Done_O` pulse, to decode. It also handles the two feedback paths: branch redirect squashes wrong-path fetches, and memory-access stall freezes the output.

## Interface
- `PC_RESET`, default 32'h0: fetch PC after reset (bits [1:0] must be 0).
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `PC` output 32: instruction memory request address.
- `Inst_Req_Valid` output 1: request valid.
- `Inst_Req_Ready` input 1: memory accepts request.
- `Instruction` input 32: response data.
- `Inst_Valid` input 1: response valid.
- `Inst_Ready` output 1: stage accepts response.
- `Feedback_Mem_Acc` input 1: downstream stall. Decode's clock is gated while this is high.
- `Feedback_Branch` input 1: redirect request.
- `Branch_Target` input 32: redirect PC.
- `Inst` output 32: fetched instruction to decode.
- `PC_O` output 32: PC of `Inst`.
- `Done_O` output 1: `Inst`/`PC_O` hold a valid instruction.

## Operation
- State machine, one-hot: s_INIT, s_IF, s_IW, s_OUT.
- **Reset** (async, `rst_n`=0) sets:
  - state=s_INIT, fetch PC=`PC_RESET`, squash flag=0.
  - `Inst`=0, `PC_O`=0, `Done_O`=0.
  - `Inst_Req_Valid`=0, `Inst_Ready`=0.
  - Asserting reset mid-transaction abandons it. Any later response is never consumed.
- **s_INIT**: go to s_IF on the first clock after reset release.
- **s_IF**: `Inst_Req_Valid`=1, `PC`=fetch PC.
  - On `Inst_Req_Ready`, go to s_IW.
- **s_IW**: `Inst_Ready`=1.
  - On `Inst_Valid` with squash=0 and no redirect: latch `Inst`<=`Instruction`, `PC_O`<=fetch PC, `Done_O`<=1, fetch PC<=fetch PC+4. Go to s_OUT.
  - On `Inst_Valid` with squash=1 or a redirect: discard the word, clear squash, go to s_IF. `Done_O` stays 0.
- **s_OUT**: `Done_O`=1. `Inst` and `PC_O` stay stable.
  - While `Feedback_Mem_Acc`=1, stay in s_OUT with no output change.
  - Otherwise decode consumes the instruction this edge. `Done_O`<=0, go to s_IF.
- **Redirect**: `Feedback_Branch`=1 is sampled only when `Feedback_Mem_Acc`=0. It has priority over sequential PC update. Target PC = {`Branch_Target`[31:2],2'b00}.
  - In s_IF without handshake: fetch PC<=target, stay in s_IF.
  - In s_IF with handshake the same cycle: the old PC was issued, so set squash=1, fetch PC<=target, go to s_IW.
  - In s_IW without `Inst_Valid`: set squash=1, fetch PC<=target.
  - In s_IW with `Inst_Valid`: discard the word, fetch PC<=target, go to s_IF.
  - In s_OUT: `Done_O`<=0, fetch PC<=target, go to s_IF. Decode drops the word itself because it ignores `Done_I` while redirect is high.
- **Stall**: s_IF and s_IW handshakes continue during stall; only s_OUT blocks.
- **PC arithmetic**: 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0. Bits [1:0] are always 0.

## Timing
- Single outstanding request. The memory may hold `Inst_Req_Ready` or `Inst_Valid` low for any number of cycles.
- Best case: request accepted at edge n, response at edge n+1, `Done_O`=1 from edge n+1 to edge n+2, next request at n+2. That is 1 instruction per 3 cycles with no stall.
- Redirect to a new request: 1 cycle. The request at the target is visible on `PC` in the cycle after the redirect edge.
- All outputs are registered or decoded from state only. No combinational path runs from `Feedback_*` to the memory handshake outputs.

## Test plan
- **Reset and first fetch**: `PC_RESET`=32'h1C000000, memory always ready, returns 32'h00000013.
  - `Inst_Req_Valid` is 0 during reset and in s_INIT.
  - First `PC`=32'h1C000000.
  - `Done_O` pulses once with `PC_O`=32'h1C000000, `Inst`=32'h00000013.
  - Next request `PC`=32'h1C000004.
- **Slow memory**: `Inst_Req_Ready` delayed 3 cycles, `Inst_Valid` delayed 4 cycles.
  - `PC` is stable throughout.
  - Exactly one `Done_O` pulse, with no duplicate.
- **Stall**: `Feedback_Mem_Acc`=1 for 5 cycles while in s_OUT.
  - `Done_O`, `Inst` and `PC_O` are held unchanged.
  - The next request issues 1 cycle after stall release.
- **Redirect in s_IW**: `Feedback_Branch`=1, `Branch_Target`=32'h00000103 while a response is pending.
  - The pending word is discarded with no `Done_O`.
  - Next `PC`=32'h00000100.
  - `PC_O`=32'h00000100 on the next pulse.
- **Redirect coinciding with handshake in s_IF**: the old-PC response is squashed, then target is fetched and delivered.
- **Redirect during stall**: `Feedback_Branch`=1 while `Feedback_Mem_Acc`=1 is ignored.
  - The same redirect, held after stall release, takes effect.
- **Wrap**: fetch PC 32'hFFFFFFFC is delivered, then the next request is `PC`=32'h00000000.
- **Async reset mid-s_IW**: `rst_n` pulses low for half a cycle.
  - Outputs clear immediately.
  - Fetch restarts at `PC_RESET`.
  - The late old response is ignored.
